// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder backed by a 2^(ADDR_WIDTH-2) x 32-bit on-chip SRAM.
// It accepts INCR, WRAP and FIXED bursts of up to 16 beats. The read and write
// channels each run their own FSM, and each allows one outstanding transaction.
//
// Ports
//   i_clk, i_rst                               clock, asynchronous active-high reset
//   arid/araddr/arlen/arsize/arburst           read address channel (arvalid in, arready out)
//   rid/rdata/rresp/rlast/rvalid, rready       read data channel
//   awid/awaddr/awlen/awsize/awburst           write address channel (awvalid in, awready out)
//   wid/wdata/wstrb/wlast/wvalid, wready       write data channel
//   bid/bresp/bvalid, bready                   write response channel
//
// Optional feature macro: AXI_SRAM_WID_CHECK_EN
//   When defined, a W beat whose wid differs from the latched awid is accepted but
//   not written, and the burst responds SLVERR. When undefined, wid is ignored.
`timescale 1ns/1ps

module axi_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    // read address channel
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data channel
    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    // write address channel
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data channel
    input  logic [ID_WIDTH-1:0] wid,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response channel
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // Word index into the array; address bits above ADDR_WIDTH alias.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_WIDTH-1:2];
    endfunction

    // Illegal burst type, or WRAP with a length that is not 2/4/8/16 beats.
    function automatic logic burst_err(input logic [1:0] burst, input logic [3:0] len);
        return (burst == 2'b11) ||
               ((burst == BURST_WRAP) &&
                !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)));
    endfunction

    // Next beat address. The burst argument is already normalised, so errored bursts arrive here as INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [2:0]  eff;
        logic [31:0] step;
        logic [31:0] mask;
        eff  = (size > 3'd2) ? 3'd2 : size;
        step = 32'd1 << eff;
        mask = ((32'(len) + 32'd1) << eff) - 32'd1;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
            default:     return addr + step;
        endcase
    endfunction

    // ---------------- read channel ----------------
    r_state_t            r_state, r_state_d;
    logic [31:0]         r_addr, r_addr_d, r_addr_n;
    logic [3:0]          r_len, r_len_d;
    logic [2:0]          r_size, r_size_d;
    logic [1:0]          r_burst, r_burst_d;
    logic [3:0]          r_cnt, r_cnt_d;
    logic                arready_d, rvalid_d, rlast_d;
    logic [ID_WIDTH-1:0] rid_d;
    logic [31:0]         rdata_d;
    logic [1:0]          rresp_d;
    logic                ar_err;

    // Read next-state and output logic.
    always_comb begin
        r_state_d = r_state;
        r_addr_d  = r_addr;
        r_len_d   = r_len;
        r_size_d  = r_size;
        r_burst_d = r_burst;
        r_cnt_d   = r_cnt;
        arready_d = arready;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rid_d     = rid;
        rdata_d   = rdata;
        rresp_d   = rresp;
        ar_err    = burst_err(arburst, arlen);
        r_addr_n  = next_addr(r_addr, r_len, r_size, r_burst);
        case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    r_state_d = R_BURST;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = ar_err ? BURST_INCR : arburst;
                    r_cnt_d   = 4'd0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (arlen == 4'd0);
                    rid_d     = arid;
                    rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = mem[word_idx(araddr)];
                end
            end
            R_BURST: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        r_addr_d = r_addr_n;
                        r_cnt_d  = r_cnt + 4'd1;
                        rlast_d  = ((r_cnt + 4'd1) == r_len);
                        rdata_d  = mem[word_idx(r_addr_n)];
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // Read state and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_state_d;
            r_addr  <= r_addr_d;
            r_len   <= r_len_d;
            r_size  <= r_size_d;
            r_burst <= r_burst_d;
            r_cnt   <= r_cnt_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rid     <= rid_d;
            rdata   <= rdata_d;
            rresp   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_t            w_state, w_state_d;
    logic [31:0]         w_addr, w_addr_d;
    logic [ID_WIDTH-1:0] w_id, w_id_d;
    logic [3:0]          w_len, w_len_d;
    logic [2:0]          w_size, w_size_d;
    logic [1:0]          w_burst, w_burst_d;
    logic [4:0]          w_cnt, w_cnt_d;      // saturates at 16 so overlong bursts never wrap
    logic                w_err, w_err_d;
    logic                awready_d, wready_d, bvalid_d;
    logic [ID_WIDTH-1:0] bid_d;
    logic [1:0]          bresp_d;
    logic                aw_err, beat_ok, err_now, wid_ok;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_widx;

`ifdef AXI_SRAM_WID_CHECK_EN
    assign wid_ok = (wid == w_id);
`else
    logic unused_wid;
    assign unused_wid = ^wid;
    assign wid_ok     = 1'b1;
`endif

    // Write next-state and output logic.
    always_comb begin
        w_state_d = w_state;
        w_addr_d  = w_addr;
        w_id_d    = w_id;
        w_len_d   = w_len;
        w_size_d  = w_size;
        w_burst_d = w_burst;
        w_cnt_d   = w_cnt;
        w_err_d   = w_err;
        awready_d = awready;
        wready_d  = wready;
        bvalid_d  = bvalid;
        bid_d     = bid;
        bresp_d   = bresp;
        aw_err    = burst_err(awburst, awlen);
        beat_ok   = 1'b0;
        err_now   = w_err;
        mem_we    = 1'b0;
        mem_widx  = word_idx(w_addr);
        case (w_state)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                if (awvalid && awready) begin
                    w_state_d = W_DATA;
                    w_addr_d  = awaddr;
                    w_id_d    = awid;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = aw_err ? BURST_INCR : awburst;
                    w_cnt_d   = 5'd0;
                    w_err_d   = aw_err;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    // Beats beyond len (or with a foreign wid) are swallowed and poison the response.
                    beat_ok  = (w_cnt <= {1'b0, w_len}) && wid_ok;
                    mem_we   = beat_ok;
                    err_now  = w_err || !beat_ok;
                    w_addr_d = next_addr(w_addr, w_len, w_size, w_burst);
                    if (w_cnt != 5'd16) begin
                        w_cnt_d = w_cnt + 5'd1;
                    end
                    if (wlast) begin
                        if (w_cnt != {1'b0, w_len}) begin
                            err_now = 1'b1;
                        end
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id;
                        bresp_d   = err_now ? RESP_SLVERR : RESP_OKAY;
                    end
                    w_err_d = err_now;
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Write state and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            w_state <= w_state_d;
            w_addr  <= w_addr_d;
            w_id    <= w_id_d;
            w_len   <= w_len_d;
            w_size  <= w_size_d;
            w_burst <= w_burst_d;
            w_cnt   <= w_cnt_d;
            w_err   <= w_err_d;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            bid     <= bid_d;
            bresp   <= bresp_d;
        end
    end

    // SRAM byte-lane writes. The array is not reset. A read of the same word
    // on the same edge sees the old value.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3 responder (slave) that models on-chip SRAM behind the CPU's AXI master ports. It accepts INCR/WRAP/FIXED bursts of up to 16 beats on the read (AR/R) and write (AW/W/B) channels. The read and write state machines are independent, with one outstanding transaction per direction. It is used as the memory endpoint in cache/uncached-path testbenches and as boot SRAM in small SoC builds.

Parameters:
ADDR_WIDTH, 16, byte-address bits decoded; the array is 2^(ADDR_WIDTH-2) 32-bit words and higher address bits alias.
ID_WIDTH, 4, width of all AXI ID fields.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/32/4/3/2  read address channel
arvalid  in  1;  arready  out  1
rid  out  ID_WIDTH;  rdata  out  32;  rresp  out  2;  rlast  out  1;  rvalid  out  1;  rready  in  1
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/32/4/3/2  write address channel
awvalid  in  1;  awready  out  1
wid  in  ID_WIDTH;  wdata  in  32;  wstrb  in  4;  wlast  in  1;  wvalid  in  1;  wready  out  1
bid  out  ID_WIDTH;  bresp  out  2;  bvalid  out  1;  bready  in  1

Behaviour:
- Reset (async, i_rst=1): read FSM goes to R_IDLE and write FSM to W_IDLE.
  - arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0.
  - rdata, rid, rresp, bid and bresp reset to 0.
  - Array contents are not reset.
  - Reset mid-burst abandons the burst; no partial B or R response is issued.
- arlock/awlock/cache/prot are not ports; unsupported.
- Read FSM R_IDLE -> R_BURST:
  - In R_IDLE, arready=1.
  - On arvalid&arready: latch id, addr, len, size and burst; set beat counter=0; register rdata<=mem[araddr[ADDR_WIDTH-1:2]].
  - rvalid rises the next cycle, so first-beat latency is 1 cycle after the AR handshake.
- In R_BURST:
  - rvalid=1 and rid=latched id; rlast=(cnt==len).
  - rdata, rid, rresp and rlast hold stable while rvalid&!rready.
  - On rvalid&rready with !rlast: advance the address, cnt++, and load rdata from the new address in the same edge. Beats are back-to-back, one per cycle when rready is held high.
  - On the rlast handshake: return to R_IDLE; arready=1 in the following cycle (no AR accept in the same cycle as rlast).
- Address advance, with step = 1<<size (size>2 is treated as 2):
  - FIXED (00): address unchanged.
  - INCR (01): addr+step, no 4KB check.
  - WRAP (10): wrap boundary = (len+1)*step; low bits wrap within the aligned block.
- Error responses:
  - WRAP with len not in {1,3,7,15}, or burst=11: behave as INCR and respond SLVERR (2'b10) on every R beat, or in bresp for writes.
  - Otherwise the response is OKAY (00).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1 and wready=0. On the AW handshake, latch fields and move to W_DATA. W data arriving before AW is not accepted.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes enabled by wstrb to mem[addr] and advances the address as for reads.
  - Beats past len are accepted but not written, and force SLVERR.
  - Leave W_DATA on the beat with wlast=1. If that beat count != len, SLVERR.
  - W_RESP: bvalid=1, bid=latched awid, bresp held until bready; then go to W_IDLE.
- Same-cycle read load and write to the same word: the read captures old data (read-before-write).
- The two FSMs never stall each other.

Optional Feature:
AXI_SRAM_WID_CHECK_EN:
- Defined: a W beat whose wid != latched awid is accepted but not written, and the burst's bresp=SLVERR.
- Undefined: wid is ignored (AXI3 non-interleaved master assumed).

Test Plan:
- Read INCR: after writing mem words 0x100..0x10C = {A0,A1,A2,A3}, send AR addr=0x100 len=3 size=2 INCR id=5 with rready=1. Required: 4 consecutive beats A0..A3, rid=5, rlast on beat 4 only, rresp=0.
- WRAP: read addr=0x108 len=3 size=2 WRAP. Required: data order 0x108, 0x10C, 0x100, 0x104.
- Write with strobe: AW 0x200 len=1 INCR, W {0xDEADBEEF strb=0xF, 0x12345678 strb=0x3}, wlast on beat 2. Required: bresp=0; mem[0x200]=0xDEADBEEF; mem[0x204] low half=0x5678 and upper half unchanged.
- Backpressure: toggle rready 1/0 every cycle during a len=15 read. Required: rdata/rlast stable while stalled; exactly 16 handshakes; arready returns 1 cycle after the last beat.
- Protocol error: AW len=3 with wlast on beat 2 -> bresp=2'b10. Separately, burst=11 read -> every rresp=2'b10.
- Async reset: assert i_rst mid-burst on both channels. Required: rvalid/bvalid/wready drop to 0 immediately; arready=awready=1; the next transaction completes normally.
